// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate D-cache: hits resolve combinationally in zero cycles;
// a miss stalls the pipeline via `miss` until line write-back/refill completes, one word per mem_ack.
module dcache_ctrl #(
    parameter int LINE_ADDR_LEN = 3,
    parameter int SET_ADDR_LEN  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_req,
    input  logic        wr_req,
    input  logic [31:0] addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        miss,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);
    localparam int TAG_ADDR_LEN = 32 - 2 - LINE_ADDR_LEN - SET_ADDR_LEN;
    localparam int LINE_WORDS   = 1 << LINE_ADDR_LEN;
    localparam int SETS         = 1 << SET_ADDR_LEN;
    localparam logic [LINE_ADDR_LEN-1:0] LAST_WORD = LINE_ADDR_LEN'(LINE_WORDS - 1);

    typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} stateT;

    stateT                    state;
    logic [LINE_ADDR_LEN-1:0] cnt;
    logic [SETS-1:0]          validArr;
    logic [SETS-1:0]          dirtyArr;
    logic [TAG_ADDR_LEN-1:0]  tagArr  [SETS];
    logic [31:0]              dataArr [SETS][LINE_WORDS];

    logic [TAG_ADDR_LEN-1:0]  reqTag;
    logic [SET_ADDR_LEN-1:0]  setIdx;
    logic [LINE_ADDR_LEN-1:0] wordIdx;
    logic                     req;
    logic                     hit;
    logic                     lastAck;
    logic                     fillWe;
    logic                     storeWe;
    logic                     unusedAddr;

    assign reqTag     = addr[31 -: TAG_ADDR_LEN];
    assign setIdx     = addr[2 + LINE_ADDR_LEN +: SET_ADDR_LEN];
    assign wordIdx    = addr[2 +: LINE_ADDR_LEN];
    assign unusedAddr = ^addr[1:0];

    assign req     = rd_req | wr_req;
    assign hit     = req & validArr[setIdx] & (tagArr[setIdx] == reqTag);
    assign miss    = (state != IDLE) | (req & ~hit);
    assign rd_data = (rd_req & ~miss) ? dataArr[setIdx][wordIdx] : '0;

    assign lastAck = mem_ack & (cnt == LAST_WORD);
    assign fillWe  = ~rst & (state == FILL) & mem_ack;
    // A simultaneous rd_req+wr_req takes the store path.
    assign storeWe = ~rst & (state == IDLE) & wr_req & hit;

    assign mem_req = (state == WRITEBACK) | (state == FILL);
    assign mem_we  = (state == WRITEBACK);

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            WRITEBACK: begin
                mem_addr  = {tagArr[setIdx], setIdx, cnt, 2'b00};
                mem_wdata = dataArr[setIdx][cnt];
            end
            FILL:    mem_addr = {reqTag, setIdx, cnt, 2'b00};
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            validArr <= '0;
            dirtyArr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req & ~hit) begin
                        cnt   <= '0;
                        state <= (validArr[setIdx] & dirtyArr[setIdx]) ? WRITEBACK : FILL;
                    end else if (storeWe) begin
                        dirtyArr[setIdx] <= 1'b1;
                    end
                end
                WRITEBACK: begin
                    if (mem_ack) begin
                        cnt <= cnt + LINE_ADDR_LEN'(1);
                        if (lastAck) state <= FILL;
                    end
                end
                FILL: begin
                    if (mem_ack) begin
                        cnt <= cnt + LINE_ADDR_LEN'(1);
                        if (lastAck) begin
                            validArr[setIdx] <= 1'b1;
                            dirtyArr[setIdx] <= 1'b0;
                            state            <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag and data storage carry no reset so they can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (fillWe) dataArr[setIdx][cnt] <= mem_rdata;
        if (fillWe & lastAck) tagArr[setIdx] <= reqTag;
        if (storeWe) dataArr[setIdx][wordIdx] <= wr_data;
    end
endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: line-level cache + memory model, per-cycle output compare, directed then random accesses.
module tb_dcache_ctrl;
    logic        clk = 1'b0;
    logic        rst, rd_req, wr_req, mem_ack;
    logic [31:0] addr, wr_data, mem_rdata;
    logic [31:0] rd_data, mem_addr, mem_wdata;
    logic        miss, mem_req, mem_we;

    always #5 clk = ~clk;

    dcache_ctrl dut (
        .clk(clk), .rst(rst), .rd_req(rd_req), .wr_req(wr_req), .addr(addr),
        .wr_data(wr_data), .rd_data(rd_data), .miss(miss), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    int nChecks = 0;
    int nFails  = 0;

    // Expected outputs for the current cycle, maintained by the stimulus thread.
    logic        chkEn = 1'b0;
    logic        expMiss, expMemReq, expMemWe, expRdChk;
    logic [31:0] expMemAddr, expMemWdata, expRd;
    int          missRun = 0;
    int          expLat  = 0;
    int          lastLat = 0;

    // Reference model: per-set line state plus a sparse backing memory.
    bit          mValid [16];
    bit          mDirty [16];
    int unsigned mTag   [16];
    logic [31:0] mLine  [16][8];
    logic [31:0] memArr [int unsigned];

    logic [31:0] xferAddr[$];
    logic [31:0] xferData[$];
    logic [31:0] obsRd;
    logic        obsMiss, obsMemReq;

    function automatic logic [31:0] memRead(input int unsigned a);
        if (memArr.exists(a)) return memArr[a];
        return a ^ 32'hC3A5_0F1E;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chkEn) begin
            check("miss", 32'(miss), 32'(expMiss));
            check("mem_req", 32'(mem_req), 32'(expMemReq));
            check("mem_we", 32'(mem_we), 32'(expMemWe));
            check("mem_addr", mem_addr, expMemAddr);
            if (!expMemReq || expMemWe) check("mem_wdata", mem_wdata, expMemWdata);
            if (expRdChk) check("rd_data", rd_data, expRd);
            if (miss) begin
                missRun++;
            end else begin
                if (missRun > 0 && expLat > 0) begin
                    check("latency", missRun + 1, expLat);
                    lastLat = missRun + 1;
                end
                missRun = 0;
            end
        end
    end

    task automatic cycleEnd();
        @(negedge clk);
        obsRd     = rd_data;
        obsMiss   = miss;
        obsMemReq = mem_req;
        if (mem_req && mem_ack) begin
            xferAddr.push_back(mem_addr);
            xferData.push_back(mem_wdata);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic setIdle();
        rd_req = 1'b0; wr_req = 1'b0; mem_ack = 1'b0;
        expMiss = 1'b0; expMemReq = 1'b0; expMemWe = 1'b0;
        expMemAddr = '0; expMemWdata = '0; expRdChk = 1'b0;
    endtask

    task automatic clearObs();
        xferAddr.delete();
        xferData.delete();
        lastLat = 0;
    endtask

    // One held access: optional write-back + refill, then the hit cycle. fixDly<0 = random ack delay.
    task automatic access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                          input int fixDly, input int rstItem);
        int unsigned s, w, t, ua;
        int          lat, dly, nItems;
        bit          dirtyVictim;
        logic [31:0] fillBuf [8];
        ua = a; s = (ua >> 5) & 15; w = (ua >> 2) & 7; t = ua >> 9;
        rd_req = rd; wr_req = wr; addr = a; wr_data = d; mem_ack = 1'b0;
        expRdChk = 1'b0; expMemReq = 1'b0; expMemWe = 1'b0; expMemAddr = '0; expMemWdata = '0;
        if (!(mValid[s] && mTag[s] == t)) begin
            dirtyVictim = mValid[s] && mDirty[s];
            nItems = dirtyVictim ? 16 : 8;
            expMiss = 1'b1;
            lat = 1;
            cycleEnd();
            for (int i = 0; i < nItems; i++) begin
                bit          isWb;
                int unsigned wi;
                logic [31:0] xa;
                isWb = dirtyVictim && i < 8;
                wi = i % 8;
                xa = isWb ? ((mTag[s] << 9) | (s << 5) | (wi << 2)) : ((t << 9) | (s << 5) | (wi << 2));
                dly = (fixDly >= 0) ? fixDly : int'($urandom_range(0, 2));
                lat += dly + 1;
                for (int k = 0; k <= dly; k++) begin
                    expMemReq = 1'b1; expMemWe = isWb; expMemAddr = xa;
                    expMemWdata = isWb ? mLine[s][wi] : 32'h0;
                    if (!isWb && int'(wi) == rstItem && k == 0) begin
                        rst = 1'b1; mem_ack = 1'b0; mem_rdata = $urandom;
                        cycleEnd();
                        rst = 1'b0;
                        setIdle();
                        expLat = 0;
                        for (int j = 0; j < 16; j++) begin
                            mValid[j] = 1'b0; mDirty[j] = 1'b0;
                        end
                        cycleEnd();
                        check("rst_mem_req", 32'(obsMemReq), 32'h0);
                        check("rst_miss", 32'(obsMiss), 32'h0);
                        return;
                    end
                    mem_ack = (k == dly);
                    mem_rdata = (!isWb && k == dly) ? memRead(xa) : $urandom;
                    cycleEnd();
                    if (k == dly) begin
                        if (isWb) memArr[xa] = mLine[s][wi];
                        else fillBuf[wi] = memRead(xa);
                    end
                end
                mem_ack = 1'b0;
            end
            mValid[s] = 1'b1; mDirty[s] = 1'b0; mTag[s] = t;
            for (int j = 0; j < 8; j++) mLine[s][j] = fillBuf[j];
            expLat = lat + 1;
        end
        expMiss = 1'b0; expMemReq = 1'b0; expMemWe = 1'b0; expMemAddr = '0; expMemWdata = '0;
        expRdChk = rd && !wr;
        expRd = mLine[s][w];
        cycleEnd();
        if (wr) begin
            mLine[s][w] = d;
            mDirty[s] = 1'b1;
        end
        setIdle();
    endtask

    initial begin
        int op;
        logic [31:0] a;
        rst = 1'b1; addr = '0; wr_data = '0; mem_rdata = '0;
        setIdle();
        for (int j = 0; j < 16; j++) begin
            mValid[j] = 1'b0; mDirty[j] = 1'b0; mTag[j] = 0;
        end
        @(posedge clk);
        #1;
        chkEn = 1'b1;
        cycleEnd();
        check("reset_rd_data", obsRd, 32'h0);
        check("reset_miss", 32'(obsMiss), 32'h0);
        rst = 1'b0;
        cycleEnd();

        // Cold read miss: eight refill words, then hit.
        clearObs();
        access(1, 0, 32'h40, 32'h0, 0, -1);
        check("t1_xfers", xferAddr.size(), 8);
        check("t1_first_addr", xferAddr[0], 32'h40);
        check("t1_last_addr", xferAddr[7], 32'h5C);
        check("t1_rd", obsRd, 32'hC3A5_0F5E);
        check("t1_latency", lastLat, 10);

        // Store hit then load.
        clearObs();
        access(0, 1, 32'h44, 32'hDEAD_BEEF, 0, -1);
        check("t2_no_xfer", xferAddr.size(), 0);
        access(1, 0, 32'h44, 32'h0, 0, -1);
        check("t2_rd", obsRd, 32'hDEAD_BEEF);

        // Conflict miss on a dirty line.
        clearObs();
        access(1, 0, 32'h840, 32'h0, 0, -1);
        check("t3_xfers", xferAddr.size(), 16);
        check("t3_wb_addr0", xferAddr[0], 32'h40);
        check("t3_wb_data1", xferData[1], 32'hDEAD_BEEF);
        check("t3_fill_addr0", xferAddr[8], 32'h840);
        check("t3_fill_addr7", xferAddr[15], 32'h85C);
        check("t3_rd", obsRd, 32'hC3A5_075E);
        check("t3_latency", lastLat, 18);

        // Slow memory: three wait cycles per word.
        clearObs();
        access(1, 0, 32'h100, 32'h0, 3, -1);
        check("t4_xfers", xferAddr.size(), 8);
        check("t4_latency", lastLat, 34);

        // Reset during refill, then the same line must refill completely.
        clearObs();
        access(1, 0, 32'h200, 32'h0, 0, 4);
        clearObs();
        access(1, 0, 32'h200, 32'h0, 0, -1);
        check("t5_xfers", xferAddr.size(), 8);
        check("t5_rd", obsRd, 32'hC3A5_0D1E);

        // Read and write together behave as a store.
        access(1, 0, 32'h48, 32'h0, 0, -1);
        clearObs();
        access(1, 1, 32'h48, 32'h1234, 0, -1);
        check("t6_no_xfer", xferAddr.size(), 0);
        access(1, 0, 32'h48, 32'h0, 0, -1);
        check("t6_rd", obsRd, 32'h1234);

        for (int n = 0; n < 120; n++) begin
            op = int'($urandom_range(0, 3));
            a = ($urandom_range(0, 3) << 9) | ($urandom_range(0, 3) << 5) |
                ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
            access(op != 2, op >= 2, a, $urandom, -1, -1);
            if ($urandom_range(0, 3) == 0) cycleEnd();
        end

        chkEn = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
